// File: rtl/bist_scheduler.sv
// Round-robin front end that shares one BIST engine between N_REQ requesters,
// sequences the start/running/finish handshake and aborts hung runs by watchdog.
module bist_scheduler #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1024,
  parameter int CW      = $clog2(TIMEOUT + 1),
  parameter int IW      = $clog2(N_REQ)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             bist_start,
  input  logic             running,
  input  logic             finish,
  input  logic             bist_end,
  output logic             engine_reset,
  output logic             done,
  output logic [IW-1:0]    done_id,
  output logic             pass,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_t;

  localparam logic [CW-1:0]    WD_LAST = CW'(TIMEOUT - 1);
  localparam logic [N_REQ-1:0] ONE     = N_REQ'(1);
  localparam logic [IW-1:0]    IDX_MAX = IW'(N_REQ - 1);

  state_t        state_q;
  logic [CW-1:0] wd_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] pick_d;
  logic          pick_vld_d;
  logic [IW-1:0] ptr_d;

  // First set request at or above the pointer, wrapping around.
  always_comb begin
    int j;
    pick_d     = '0;
    pick_vld_d = 1'b0;
    j          = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(ptr_q) + i) % N_REQ;
      if (!pick_vld_d && req[j]) begin
        pick_vld_d = 1'b1;
        pick_d     = IW'(j);
      end
    end
  end

  assign ptr_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      wd_q         <= '0;
      ptr_q        <= '0;
      idx_q        <= '0;
      grant        <= '0;
      bist_start   <= 1'b0;
      engine_reset <= 1'b0;
      done         <= 1'b0;
      done_id      <= '0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld_d) begin
            state_q    <= START;
            idx_q      <= pick_d;
            grant      <= ONE << pick_d;
            wd_q       <= '0;
            bist_start <= 1'b1;
            busy       <= 1'b1;
          end
        end
        START, RUN: begin
          // finish beats watchdog expiry when both land in the same cycle
          if (finish) begin
            state_q    <= DONE;
            bist_start <= 1'b0;
            done       <= 1'b1;
            done_id    <= idx_q;
            pass       <= bist_end;
            timeout    <= 1'b0;
          end else if (wd_q == WD_LAST) begin
            state_q      <= ABORT;
            bist_start   <= 1'b0;
            engine_reset <= 1'b1;
            done         <= 1'b1;
            done_id      <= idx_q;
            pass         <= 1'b0;
            timeout      <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
            if (state_q == START && running) begin
              state_q    <= RUN;
              bist_start <= 1'b0;
            end
          end
        end
        DONE, ABORT: begin
          state_q      <= IDLE;
          grant        <= '0;
          ptr_q        <= ptr_d;
          engine_reset <= 1'b0;
          done         <= 1'b0;
          pass         <= 1'b0;
          timeout      <= 1'b0;
          busy         <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
